// File: rtl/mem_be_sp_if.sv
// Request/response bus of the byte-enable single-port memory.
// The requester drives the request side through the master modport,
// the memory answers through the slave modport.
interface mem_be_sp_if #(
    parameter int W  = 16,
    parameter int AD = 9
);
    logic            valid_i;
    logic            ready_o;
    logic            wr_rd_i;
    logic [AD-1:0]   addr_i;
    logic [W-1:0]    write_i;
    logic [W/8-1:0]  be_i;
    logic            init_i;
    logic [W-1:0]    read_o;
    logic            rvalid_o;
    logic            err_o;
    logic            init_done_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, write_i, be_i, init_i,
        input  ready_o, read_o, rvalid_o, err_o, init_done_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, write_i, be_i, init_i,
        output ready_o, read_o, rvalid_o, err_o, init_done_o
    );
endinterface

// File: rtl/mem_be_sp.sv
// Single-port RAM with valid/ready requests, per-byte write enables,
// read latency of 1 or 2 cycles, out-of-range error pulses and a
// sequential clear sweep that runs after reset and on init_i.
// The array has no reset so it maps onto block RAM; zeroing is done
// one word per cycle by the sweep.
module mem_be_sp #(
    parameter int W      = 16,
    parameter int D      = 512,
    parameter int AD     = 9,
    parameter int RD_LAT = 1   // 1 or 2; any value other than 1 builds the 2-cycle pipe
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_be_sp_if.slave    bus
);
    localparam int NB = W / 8;
    localparam logic [AD-1:0] LAST_ADDR = AD'(D - 1);
    localparam logic [AD:0]   D_EXT     = (AD + 1)'(D);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AD-1:0]   cnt_reg, cnt_next;

    logic            accept;
    logic            in_range;
    logic            wr_en;
    logic            rd_en;
    logic            sweep_we;
    logic [AD-1:0]   ram_addr;
    logic [W-1:0]    ram_q;

    logic            rv1_reg;
    logic            oor1_reg;
    logic            err_reg;
    logic [W-1:0]    resp_data;

    // Request decode; nothing is accepted while the sweep owns the port.
    assign accept   = bus.valid_i && (state_reg == ST_READY);
    assign in_range = ({1'b0, bus.addr_i} < D_EXT);
    assign wr_en    = accept && bus.wr_rd_i && in_range;
    assign rd_en    = accept && !bus.wr_rd_i && in_range;
    assign sweep_we = (state_reg == ST_INIT);
    assign ram_addr = sweep_we ? cnt_reg : bus.addr_i;

    // Control state and sweep counter; reset always restarts the sweep at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: sweep walks 0..D-1, init_i in READY restarts it.
    // A request on the init_i edge is still accepted because accept only
    // looks at the current state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + AD'(1);
                end
            end
            ST_READY: begin
                if (bus.init_i) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.ready_o     = (state_reg == ST_READY);
    assign bus.init_done_o = (state_reg == ST_READY);

    // One 8-bit RAM per byte lane so each lane has its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [0:D-1];
            logic [7:0] lane_q_reg;

            // Lane write (sweep or byte-enabled request) and read-first registered read.
            always_ff @(posedge clk_i) begin
                if (sweep_we) begin
                    lane_mem[ram_addr] <= 8'h00;
                end else if (wr_en && bus.be_i[gi]) begin
                    lane_mem[ram_addr] <= bus.write_i[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_q_reg <= lane_mem[ram_addr];
                end
            end

            assign ram_q[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    // First response stage: read/error flags aligned with the RAM output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv1_reg  <= 1'b0;
            oor1_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            rv1_reg  <= accept && !bus.wr_rd_i;
            oor1_reg <= accept && !bus.wr_rd_i && !in_range;
            err_reg  <= accept && !in_range;
        end
    end

    // Out-of-range reads return zero instead of whatever the RAM register holds.
    assign resp_data  = oor1_reg ? '0 : ram_q;
    assign bus.err_o  = err_reg;

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic [W-1:0] hold_reg;

            // Remember the last delivered word so read_o is stable between pulses.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hold_reg <= '0;
                end else if (rv1_reg) begin
                    hold_reg <= resp_data;
                end
            end

            // Pure select between registers; no input reaches read_o combinationally.
            assign bus.rvalid_o = rv1_reg;
            assign bus.read_o   = rv1_reg ? resp_data : hold_reg;
        end else begin : g_lat2
            logic         rv2_reg;
            logic [W-1:0] read_reg;

            // Second stage: output register, loaded only when a response arrives.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rv2_reg  <= 1'b0;
                    read_reg <= '0;
                end else begin
                    rv2_reg <= rv1_reg;
                    if (rv1_reg) begin
                        read_reg <= resp_data;
                    end
                end
            end

            assign bus.rvalid_o = rv2_reg;
            assign bus.read_o   = read_reg;
        end
    endgenerate
endmodule

// File: doc/mem_be_sp.md
# mem_be_sp

Single-port synchronous RAM with a valid/ready request handshake, per-byte write enables, a configurable read latency, out-of-range error reporting and a hardware clear sequencer. It runs after reset and on demand. It is the parametrised successor to the team's basic handshake memory. It sits behind a bus-side requester that issues at most one read or write per cycle. Memory contents are zeroed by a sequential sweep, not by reset, so the array maps onto block RAM.

## Interface

Parameters:

- W, 16, data width in bits; must be a multiple of 8.
- D, 512, number of words; must be at least 2 and at most 2^AD.
- AD, 9, address width in bits.
- RD_LAT, 1, read latency in cycles from acceptance to rvalid_o; legal values are 1 and 2.

Ports:

- clk_i, input, 1, clock; all logic is on the rising edge.
- rst_ni, input, 1, reset; one clock, asynchronous assert, active-low (per the Already-decided line); deassertion is synchronous to clk_i externally.
- valid_i, input, 1, request valid.
- ready_o, output, 1, block can accept a request this cycle.
- wr_rd_i, input, 1, 1 = write, 0 = read.
- addr_i, input, AD, word address.
- write_i, input, W, write data.
- be_i, input, W/8, byte enables for writes; bit k enables write_i[8k+7:8k]; ignored on reads.
- init_i, input, 1, pulse to request a clear sweep.
- read_o, output, W, read data; valid only while rvalid_o = 1.
- rvalid_o, output, 1, read data valid; 1-cycle pulse per accepted read.
- err_o, output, 1, 1-cycle pulse for an accepted request with addr_i >= D.
- init_done_o, output, 1, 1 when no clear sweep is running.

## Operation

- FSM states:
  - INIT: sweep counter cnt walks 0..D-1 and writes mem[cnt] = 0, one word per cycle; ready_o = 0 and init_done_o = 0.
  - READY: ready_o = 1 and init_done_o = 1.
- Transitions:
  - Reset always enters INIT with cnt = 0.
  - INIT goes to READY on the edge that clears word D-1.
  - READY goes to INIT with cnt = 0 on an edge where init_i = 1.
  - If init_i = 1 and valid_i = 1 on the same edge, the request is accepted and executed first; the sweep starts on the next cycle.
  - init_i is ignored while in INIT.
- Acceptance: a request is accepted on an edge where valid_i & ready_o = 1. Requests while ready_o = 0 are not accepted and have no effect; the requester must hold them.
- Write: for each k with be_i[k] = 1, mem[addr_i] byte k takes write_i byte k; other bytes keep their value. be_i = 0 is a legal no-op and still completes.
- Read: read_o holds mem[addr_i] as it stood after all earlier accepted writes. A read accepted the cycle after a write to the same address returns the new data.
- Out of range (addr_i >= D): writes are dropped. Reads still produce rvalid_o, with read_o = 0. err_o pulses on both.
- There is no response backpressure. One read can be accepted per cycle; with RD_LAT = 2, two reads can be in flight.
- Reads accepted before init_i complete normally during the sweep, returning pre-sweep data.
- Reset mid-operation: all in-flight reads are discarded with no rvalid_o, the control registers clear, and the sweep restarts from 0. Memory contents are undefined until that sweep completes.

## Timing

- Reset values:
  - ready_o = 0
  - rvalid_o = 0
  - err_o = 0
  - init_done_o = 0
  - read_o = 0
  - cnt = 0
  - FSM = INIT
- Sweep length: ready_o and init_done_o rise after exactly D rising edges following reset deassertion, or following the init_i edge.
- Read latency: a read accepted on edge t gives rvalid_o = 1 and valid read_o during the cycle after edge t + RD_LAT - 1. For RD_LAT = 1, the response is in the cycle immediately following acceptance.
- err_o: high in the cycle following the accepting edge, for both reads and writes, independent of RD_LAT.
- read_o holds its last value when rvalid_o = 0. Outputs are never combinational from inputs; all are registered.

## Test plan

- Reset and sweep, D = 512: release rst_ni -> ready_o = 0 for 512 edges, then ready_o = 1 and init_done_o = 1; reading addresses 0, 255 and 511 returns 0x0000.
- Byte enables: write 0xABCD to addr 5 with be = 2'b11, then write 0x1234 with be = 2'b01, then read addr 5 -> read_o = 0xAB34, with rvalid_o exactly 1 cycle after acceptance (RD_LAT = 1).
- Back-to-back, RD_LAT = 2: write 0x00FF to addr 7, then on consecutive cycles read 7 and read 8 -> two consecutive rvalid_o pulses 2 cycles after each acceptance, read_o = 0x00FF then 0x0000.
- Out of range, D = 500: write 0x5555 to addr 510 -> err_o pulses on the next cycle; a following read of addr 510 -> err_o pulse and read_o = 0 with rvalid_o; addr 499 is unchanged.
- Soft clear: with addr 3 = 0x1111, pulse init_i while also issuing a read of 3 -> rvalid_o with 0x1111; ready_o is low for 512 cycles; a read of 3 after the sweep returns 0.
- Reset mid-read, RD_LAT = 2: assert rst_ni low 1 cycle after a read is accepted -> no rvalid_o, all outputs at reset values, and the sweep restarts.
